// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants for the radix-2 FFT family: Q1.14 twiddle
//                tables for up to 64 points, controller state encodings and
//                the bit-reversal helper used for in-place DIT ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int N_MAX      = 64;
    localparam int TW_W       = 16;
    localparam int TW_FRAC    = 14;
    localparam int TW_ENTRIES = N_MAX / 2;

    // Controller states: capture, in-place butterflies, drain.
    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_UNLOAD  = 2'd2;

    // cos(2*pi*t/64) in Q1.14, t = 0..31
    localparam logic signed [TW_W-1:0] TW_COS [0:TW_ENTRIES-1] = '{
         16'sd16384,  16'sd16305,  16'sd16069,  16'sd15679,
         16'sd15137,  16'sd14449,  16'sd13623,  16'sd12665,
         16'sd11585,  16'sd10394,  16'sd9102,   16'sd7723,
         16'sd6270,   16'sd4756,   16'sd3196,   16'sd1606,
         16'sd0,     -16'sd1606,  -16'sd3196,  -16'sd4756,
        -16'sd6270,  -16'sd7723,  -16'sd9102,  -16'sd10394,
        -16'sd11585, -16'sd12665, -16'sd13623, -16'sd14449,
        -16'sd15137, -16'sd15679, -16'sd16069, -16'sd16305
    };

    // sin(2*pi*t/64) in Q1.14, t = 0..31
    localparam logic signed [TW_W-1:0] TW_SIN [0:TW_ENTRIES-1] = '{
         16'sd0,      16'sd1606,   16'sd3196,   16'sd4756,
         16'sd6270,   16'sd7723,   16'sd9102,   16'sd10394,
         16'sd11585,  16'sd12665,  16'sd13623,  16'sd14449,
         16'sd15137,  16'sd15679,  16'sd16069,  16'sd16305,
         16'sd16384,  16'sd16305,  16'sd16069,  16'sd15679,
         16'sd15137,  16'sd14449,  16'sd13623,  16'sd12665,
         16'sd11585,  16'sd10394,  16'sd9102,   16'sd7723,
         16'sd6270,   16'sd4756,   16'sd3196,   16'sd1606
    };

    // Reverse the low 'bits' bits of k (bits = 1..6): mirror all six bits,
    // then shift the mirrored field down into place.
    function automatic logic [5:0] bitrev(input logic [5:0] k, input int bits);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i] = k[5-i];
        end
        return r >> (6 - bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bfly.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bfly
//  Description : Combinational radix-2 DIT butterfly. A' = A + W*B and
//                B' = A - W*B with W = cos -/+ j*sin (sign picked by
//                i_inverse). Optional divide-by-two on the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_bfly
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SCALE  = 0
) (
    input  logic signed [DATA_W-1:0] i_a_re,
    input  logic signed [DATA_W-1:0] i_a_im,
    input  logic signed [DATA_W-1:0] i_b_re,
    input  logic signed [DATA_W-1:0] i_b_im,
    input  logic signed [TW_W-1:0]   i_tw_cos,
    input  logic signed [TW_W-1:0]   i_tw_sin,
    input  logic                     i_inverse,
    output logic signed [DATA_W-1:0] o_a_re,
    output logic signed [DATA_W-1:0] o_a_im,
    output logic signed [DATA_W-1:0] o_b_re,
    output logic signed [DATA_W-1:0] o_b_im
);

    // Wide enough for a full twiddle x sample product plus the cross-term sum.
    localparam int PW = TW_W + DATA_W;

    logic signed [TW_W-1:0] w_wi;
    logic signed [PW:0]     w_wr_x, w_wi_x, w_are_x, w_aim_x, w_bre_x, w_bim_x;
    logic signed [PW:0]     w_pr_sum, w_pi_sum, w_pr, w_pi;
    logic signed [PW:0]     w_s0_re, w_s0_im, w_s1_re, w_s1_im;
    logic                   w_unused;

    // Forward transform uses the conjugate-sine twiddle, inverse the plain one.
    assign w_wi = i_inverse ? i_tw_sin : -i_tw_sin;

    assign w_wr_x  = (PW+1)'(i_tw_cos);
    assign w_wi_x  = (PW+1)'(w_wi);
    assign w_are_x = (PW+1)'(i_a_re);
    assign w_aim_x = (PW+1)'(i_a_im);
    assign w_bre_x = (PW+1)'(i_b_re);
    assign w_bim_x = (PW+1)'(i_b_im);

    // Complex product W*B; each cross-term sum is floored back to sample scale.
    assign w_pr_sum = w_wr_x * w_bre_x - w_wi_x * w_bim_x;
    assign w_pi_sum = w_wr_x * w_bim_x + w_wi_x * w_bre_x;
    assign w_pr     = w_pr_sum >>> TW_FRAC;
    assign w_pi     = w_pi_sum >>> TW_FRAC;

    assign w_s0_re = w_are_x + w_pr;
    assign w_s0_im = w_aim_x + w_pi;
    assign w_s1_re = w_are_x - w_pr;
    assign w_s1_im = w_aim_x - w_pi;

    // Only the low DATA_W+1 bits of each sum matter: scaled outputs take the
    // floor-halved field, unscaled ones wrap modulo 2^DATA_W.
    assign o_a_re = (SCALE != 0) ? w_s0_re[DATA_W:1] : w_s0_re[DATA_W-1:0];
    assign o_a_im = (SCALE != 0) ? w_s0_im[DATA_W:1] : w_s0_im[DATA_W-1:0];
    assign o_b_re = (SCALE != 0) ? w_s1_re[DATA_W:1] : w_s1_re[DATA_W-1:0];
    assign o_b_im = (SCALE != 0) ? w_s1_im[DATA_W:1] : w_s1_im[DATA_W-1:0];

    assign w_unused = ^{w_s0_re, w_s0_im, w_s1_re, w_s1_im};

endmodule
`default_nettype wire

// File: rtl/fft_r2_iter.sv
`default_nettype none
// ============================================================================
//  Module      : fft_r2_iter
//  Description : Iterative radix-2 DIT FFT/IFFT. Samples are captured in
//                bit-reversed order, transformed in place by one shared
//                butterfly (one per clock), then drained in natural order.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_r2_iter
    import fft_pkg::*;
#(
    parameter int N      = 8,
    parameter int LOG2N  = 3,
    parameter int DATA_W = 16,
    parameter int SCALE  = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic                     inverse,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]         out_index,
    output logic                     out_last,
    output logic                     busy
);

    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    localparam logic [LOG2N-1:0] c_cnt_last  = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] c_half_last = LOG2N'(N/2 - 1);
    localparam logic [SW-1:0]    c_stg_last  = SW'(LOG2N - 1);

    logic [1:0]              r_state;
    logic [LOG2N-1:0]        r_cnt;      // k in LOAD, j in COMPUTE, idx in UNLOAD
    logic [SW-1:0]           r_stage;
    logic                    r_inv;
    logic signed [DATA_W-1:0] r_mem_re [N];
    logic signed [DATA_W-1:0] r_mem_im [N];

    logic [LOG2N-1:0]        w_load_addr;
    logic [LOG2N-1:0]        w_h, w_m, w_top, w_bot;
    logic [4:0]              w_tw_idx;
    logic                    w_accept;
    logic signed [DATA_W-1:0] w_y0_re, w_y0_im, w_y1_re, w_y1_im;

    assign w_accept    = (r_state == ST_LOAD) && in_valid;
    assign w_load_addr = LOG2N'(bitrev(6'(r_cnt), LOG2N));

    // Butterfly addressing: span h = 2^s, pair offset m within its group.
    assign w_h      = LOG2N'(1) << r_stage;
    assign w_m      = r_cnt & (w_h - 1'b1);
    assign w_top    = (((r_cnt >> r_stage) << r_stage) << 1) | w_m;
    assign w_bot    = w_top | w_h;
    // Twiddle step in the 64-entry circle is 64/(2h) = 32 >> s.
    assign w_tw_idx = 5'((11'(w_m) << 5) >> r_stage);

    fft_bfly #(
        .DATA_W (DATA_W),
        .SCALE  (SCALE)
    ) u_bfly (
        .i_a_re    (r_mem_re[w_top]),
        .i_a_im    (r_mem_im[w_top]),
        .i_b_re    (r_mem_re[w_bot]),
        .i_b_im    (r_mem_im[w_bot]),
        .i_tw_cos  (TW_COS[w_tw_idx]),
        .i_tw_sin  (TW_SIN[w_tw_idx]),
        .i_inverse (r_inv),
        .o_a_re    (w_y0_re),
        .o_a_im    (w_y0_im),
        .o_b_re    (w_y1_re),
        .o_b_im    (w_y1_im)
    );

    // Frame controller: capture N samples, run LOG2N stages of N/2 butterflies,
    // then hand out N bins; a reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_stage <= '0;
            r_inv   <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (r_cnt == '0) begin
                            r_inv <= inverse;
                        end
                        if (r_cnt == c_cnt_last) begin
                            r_cnt   <= '0;
                            r_stage <= '0;
                            r_state <= ST_COMPUTE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt <= '0;
                        if (r_stage == c_stg_last) begin
                            r_state <= ST_UNLOAD;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (r_cnt == c_cnt_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Sample array: bit-reversed capture writes, in-place butterfly write-back.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (w_accept) begin
                r_mem_re[w_load_addr] <= in_re;
                r_mem_im[w_load_addr] <= in_im;
            end else if (r_state == ST_COMPUTE) begin
                r_mem_re[w_top] <= w_y0_re;
                r_mem_im[w_top] <= w_y0_im;
                r_mem_re[w_bot] <= w_y1_re;
                r_mem_im[w_bot] <= w_y1_im;
            end
        end
    end

    assign in_ready  = (r_state == ST_LOAD);
    assign busy      = (r_state != ST_LOAD);
    assign out_valid = (r_state == ST_UNLOAD);
    assign out_index = out_valid ? r_cnt : '0;
    assign out_last  = out_valid && (r_cnt == c_cnt_last);
    assign out_re    = out_valid ? r_mem_re[r_cnt] : '0;
    assign out_im    = out_valid ? r_mem_im[r_cnt] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_r2_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_r2_iter
//  Description : Directed self-checking bench for fft_r2_iter. Three DUT
//                instances (N=8 unscaled, N=8 scaled, N=16 unscaled) share
//                clock, reset and input data; a selector routes the handshake
//                and outputs of the instance under test.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_r2_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic               reset_n;
    logic signed [15:0] in_re, in_im;
    logic               inverse;
    logic               out_ready;

    logic               iv0, ir0, ov0, ol0, bz0;
    logic signed [15:0] ore0, oim0;
    logic [2:0]         oix0;
    logic               iv1, ir1, ov1, ol1, bz1;
    logic signed [15:0] ore1, oim1;
    logic [2:0]         oix1;
    logic               iv2, ir2, ov2, ol2, bz2;
    logic signed [15:0] ore2, oim2;
    logic [3:0]         oix2;

    fft_r2_iter #(.N(8), .LOG2N(3), .DATA_W(16), .SCALE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv0), .in_ready(ir0),
        .in_re(in_re), .in_im(in_im), .inverse(inverse), .out_valid(ov0),
        .out_ready(out_ready), .out_re(ore0), .out_im(oim0), .out_index(oix0),
        .out_last(ol0), .busy(bz0));

    fft_r2_iter #(.N(8), .LOG2N(3), .DATA_W(16), .SCALE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1),
        .in_re(in_re), .in_im(in_im), .inverse(inverse), .out_valid(ov1),
        .out_ready(out_ready), .out_re(ore1), .out_im(oim1), .out_index(oix1),
        .out_last(ol1), .busy(bz1));

    fft_r2_iter #(.N(16), .LOG2N(4), .DATA_W(16), .SCALE(0)) u2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv2), .in_ready(ir2),
        .in_re(in_re), .in_im(in_im), .inverse(inverse), .out_valid(ov2),
        .out_ready(out_ready), .out_re(ore2), .out_im(oim2), .out_index(oix2),
        .out_last(ol2), .busy(bz2));

    int                 sel = 0;
    logic               m_ir, m_ov, m_last, m_busy;
    logic signed [15:0] m_re, m_im;
    int                 m_idx;

    always_comb begin
        m_ir = ir0; m_ov = ov0; m_last = ol0; m_busy = bz0;
        m_re = ore0; m_im = oim0; m_idx = int'(oix0);
        if (sel == 1) begin
            m_ir = ir1; m_ov = ov1; m_last = ol1; m_busy = bz1;
            m_re = ore1; m_im = oim1; m_idx = int'(oix1);
        end else if (sel == 2) begin
            m_ir = ir2; m_ov = ov2; m_last = ol2; m_busy = bz2;
            m_re = ore2; m_im = oim2; m_idx = int'(oix2);
        end
    end

    int checks   = 0;
    int failures = 0;
    int t_acc    = 0;
    int vec_re [16];
    int vec_im [16];
    int exp_re [16];
    int exp_im [16];
    logic [15:0] bp_pat = 16'b1001_1010_0110_0101;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_valid(input int s, input logic v);
        if (s == 0) iv0 = v;
        else if (s == 1) iv1 = v;
        else iv2 = v;
    endtask

    // Drive one frame; 'gap' idle cycles follow each sample. inverse is only
    // meaningful with sample 0, so the other samples carry the opposite value.
    task automatic send_frame(input int s, input int n, input logic inv, input int gap);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            set_valid(s, 1'b1);
            in_re   = 16'(vec_re[k]);
            in_im   = 16'(vec_im[k]);
            inverse = (k == 0) ? inv : ~inv;
            if (k == 0) t_acc = cyc;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                set_valid(s, 1'b0);
            end
        end
        @(negedge clk);
        set_valid(s, 1'b0);
        inverse = 1'b0;
    endtask

    // Drain one frame and compare every observed bin against exp_*.
    // bp: pseudo-random out_ready; junk: hold in_valid high with garbage
    // while the engine is busy; lat: check first-bin latency.
    task automatic unload_frame(input int s, input int n, input bit bp,
                                input bit junk, input bit lat);
        int  idx   = 0;
        int  guard = 0;
        bit  first = 1'b1;
        logic rdy;
        if (junk) begin
            set_valid(s, 1'b1);
            in_re = 16'sh7abc;
            in_im = -16'sd1234;
        end
        while (idx < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (bp) begin
                rdy    = bp_pat[0];
                bp_pat = {bp_pat[0], bp_pat[15:1]};
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            if (m_ov) begin
                if (first) begin
                    first = 1'b0;
                    if (lat) check("first_bin_latency", cyc - t_acc, 20);
                end
                check($sformatf("bin%0d_index", idx), m_idx, idx);
                check($sformatf("bin%0d_re", idx), m_re, exp_re[idx]);
                check($sformatf("bin%0d_im", idx), m_im, exp_im[idx]);
                check($sformatf("bin%0d_last", idx), m_last, (idx == n-1) ? 1 : 0);
                if (rdy) begin
                    if (junk && idx == n-1) set_valid(s, 1'b0);
                    idx++;
                end
            end
        end
        if (idx < n) check("unload_timeout_bins", idx, n);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_frame_in_ready", m_ir, 1);
        check("post_frame_out_valid", m_ov, 0);
        check("post_frame_busy", m_busy, 0);
    endtask

    // re = {50,50,50,50,0,0,0,0}. Forward bins 1/3/5/7 have imag -121/-21/21/121;
    // inverse gives 120/20/-20/-120 (floor of +/-70.7 in the last stage).
    task automatic set_scen1(input bit inv);
        for (int k = 0; k < 8; k++) begin
            vec_re[k] = (k < 4) ? 50 : 0;
            vec_im[k] = 0;
            exp_re[k] = (k == 0) ? 200 : ((k % 2 == 1) ? 50 : 0);
            exp_im[k] = 0;
        end
        exp_im[1] = inv ? 120  : -121;
        exp_im[3] = inv ? 20   : -21;
        exp_im[5] = inv ? -20  : 21;
        exp_im[7] = inv ? -120 : 121;
    endtask

    task automatic set_impulse(input int amp, input int bin_val, input int n);
        for (int k = 0; k < 16; k++) begin
            vec_re[k] = (k == 0) ? amp : 0;
            vec_im[k] = 0;
            exp_re[k] = (k < n) ? bin_val : 0;
            exp_im[k] = 0;
        end
    endtask

    initial begin
        reset_n = 1'b0; iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        in_re = '0; in_im = '0; inverse = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        sel = 0;
        check("rst_in_ready", m_ir, 1);
        check("rst_out_valid", m_ov, 0);
        check("rst_busy", m_busy, 0);
        check("rst_out_last", m_last, 0);
        check("rst_out_index", m_idx, 0);
        check("rst_out_re", m_re, 0);
        check("rst_out_im", m_im, 0);
        reset_n = 1'b1;

        // N=8 forward, gap-free, with first-bin latency
        set_scen1(1'b0);
        send_frame(0, 8, 1'b0, 0);
        unload_frame(0, 8, 1'b0, 1'b0, 1'b1);

        // N=8 inverse latched from the first sample only
        set_scen1(1'b1);
        send_frame(0, 8, 1'b1, 0);
        unload_frame(0, 8, 1'b0, 1'b0, 1'b1);

        // N=8 forward again with valid every 3rd cycle and output backpressure
        set_scen1(1'b0);
        send_frame(0, 8, 1'b0, 2);
        unload_frame(0, 8, 1'b1, 1'b0, 1'b0);

        // N=8 SCALE=1 impulse: 1000/8 in every bin
        sel = 1;
        set_impulse(1000, 125, 8);
        send_frame(1, 8, 1'b0, 0);
        unload_frame(1, 8, 1'b0, 1'b0, 1'b1);

        // N=16 DC input, inverse then forward; in_valid kept high while busy
        sel = 2;
        for (int k = 0; k < 16; k++) begin
            vec_re[k] = 1000; vec_im[k] = 0;
            exp_re[k] = (k == 0) ? 16000 : 0; exp_im[k] = 0;
        end
        send_frame(2, 16, 1'b1, 0);
        unload_frame(2, 16, 1'b1, 1'b1, 1'b0);
        send_frame(2, 16, 1'b0, 0);
        unload_frame(2, 16, 1'b0, 1'b1, 1'b0);

        // Reset on COMPUTE cycle 5, then a fresh impulse frame
        sel = 0;
        set_impulse(1000, 1000, 8);
        send_frame(0, 8, 1'b0, 0);
        repeat (5) @(negedge clk);
        check("mid_compute_busy", m_busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", m_ir, 1);
        check("mid_rst_out_valid", m_ov, 0);
        check("mid_rst_busy", m_busy, 0);
        reset_n = 1'b1;
        send_frame(0, 8, 1'b0, 0);
        unload_frame(0, 8, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
